// File: rtl/uart_link_if.sv
// uart_link_if -- bundles the serial lines and the byte-level RX/TX status
// and control signals of uart_link. The slave modport is the UART side, the
// master modport is the side that feeds bytes in and watches the counters.
interface uart_link_if;
  logic       rx;
  logic       tx;
  logic [7:0] rhr_data;
  logic [7:0] rx_data_ready;
  logic       rx_error;
  logic       tx_load;
  logic [7:0] tx_out_data;
  logic [7:0] tx_count;
  logic       tx_busy;

  modport master (
    output rx, tx_load, tx_out_data,
    input  tx, rhr_data, rx_data_ready, rx_error, tx_count, tx_busy
  );

  modport slave (
    input  rx, tx_load, tx_out_data,
    output tx, rhr_data, rx_data_ready, rx_error, tx_count, tx_busy
  );
endinterface

// File: rtl/uart_link.sv
// uart_link -- full-duplex UART, 8N1 by default.
// Defining UART_LINK_PARITY_EN switches both directions to 8E1 (even parity
// bit between data bit 7 and the stop bit); the port list is unchanged.
// RX and TX are independent FSMs sharing only clk and reset_n.
module uart_link #(
  parameter int CLKS_PER_BIT = 434  // clk cycles per serial bit, 4..65535
) (
  input  logic  clk,
  input  logic  reset_n,
  uart_link_if.slave bus
);

  localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);

`ifdef UART_LINK_PARITY_EN
  typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_PARITY, R_STOP} rx_state_t;
  typedef enum logic [2:0] {T_IDLE, T_ARM, T_START, T_DATA, T_PARITY, T_STOP} tx_state_t;
`else
  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
  typedef enum logic [2:0] {T_IDLE, T_ARM, T_START, T_DATA, T_STOP} tx_state_t;
`endif

  // ---------------------------------------------------------------- RX
  logic        r_rx_s1, r_rx_s2;
  rx_state_t   r_rx_state, w_rx_state_nxt;
  logic [15:0] r_rx_cnt, w_rx_cnt_nxt;
  logic [2:0]  r_rx_idx, w_rx_idx_nxt;
  logic [7:0]  r_rx_shift, w_rx_shift_nxt;
  logic        r_rx_stop_bad, w_rx_stop_bad_nxt;
  logic [7:0]  r_rhr_data, w_rhr_data_nxt;
  logic [7:0]  r_rx_data_ready, w_rx_data_ready_nxt;
  logic        r_rx_error, w_rx_error_nxt;
  logic        w_rx_par_ok;

`ifdef UART_LINK_PARITY_EN
  logic        r_rx_par_bad, w_rx_par_bad_nxt;
  assign w_rx_par_ok = ~r_rx_par_bad;
`else
  assign w_rx_par_ok = 1'b1;
`endif

  // Two-flop synchroniser on the asynchronous rx line; idles high.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rx_s1 <= 1'b1;
      r_rx_s2 <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments in clocked blocks so every flop sees
      // the pre-edge value of its neighbours, exactly like real hardware.
      r_rx_s1 <= bus.rx;
      r_rx_s2 <= r_rx_s1;
    end
  end

  // RX state and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rx_state      <= R_IDLE;
      r_rx_cnt        <= '0;
      r_rx_idx        <= '0;
      r_rx_shift      <= '0;
      r_rx_stop_bad   <= 1'b0;
      r_rhr_data      <= '0;
      r_rx_data_ready <= '0;
      r_rx_error      <= 1'b0;
`ifdef UART_LINK_PARITY_EN
      r_rx_par_bad    <= 1'b0;
`endif
    end else begin
      r_rx_state      <= w_rx_state_nxt;
      r_rx_cnt        <= w_rx_cnt_nxt;
      r_rx_idx        <= w_rx_idx_nxt;
      r_rx_shift      <= w_rx_shift_nxt;
      r_rx_stop_bad   <= w_rx_stop_bad_nxt;
      r_rhr_data      <= w_rhr_data_nxt;
      r_rx_data_ready <= w_rx_data_ready_nxt;
      r_rx_error      <= w_rx_error_nxt;
`ifdef UART_LINK_PARITY_EN
      r_rx_par_bad    <= w_rx_par_bad_nxt;
`endif
    end
  end

  // RX next-state: find the start-bit midpoint, then sample once per bit.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    w_rx_state_nxt      = r_rx_state;
    w_rx_cnt_nxt        = r_rx_cnt + 16'd1;
    w_rx_idx_nxt        = r_rx_idx;
    w_rx_shift_nxt      = r_rx_shift;
    w_rx_stop_bad_nxt   = r_rx_stop_bad;
    w_rhr_data_nxt      = r_rhr_data;
    w_rx_data_ready_nxt = r_rx_data_ready;
    w_rx_error_nxt      = r_rx_error;
`ifdef UART_LINK_PARITY_EN
    w_rx_par_bad_nxt    = r_rx_par_bad;
`endif
    case (r_rx_state)
      R_IDLE: begin
        w_rx_cnt_nxt = '0;
        if (!r_rx_s2) w_rx_state_nxt = R_START;
      end
      R_START: begin
        if (r_rx_cnt == HALF_LAST) begin
          w_rx_cnt_nxt = '0;
          w_rx_idx_nxt = '0;
          // A line that is high again at mid-start was only a glitch.
          w_rx_state_nxt = r_rx_s2 ? R_IDLE : R_DATA;
        end
      end
      R_DATA: begin
        if (r_rx_cnt == BIT_LAST) begin
          w_rx_cnt_nxt   = '0;
          w_rx_shift_nxt = {r_rx_s2, r_rx_shift[7:1]};
          w_rx_idx_nxt   = r_rx_idx + 3'd1;
          if (r_rx_idx == 3'd7) begin
`ifdef UART_LINK_PARITY_EN
            w_rx_state_nxt = R_PARITY;
`else
            w_rx_state_nxt = R_STOP;
`endif
          end
        end
      end
`ifdef UART_LINK_PARITY_EN
      R_PARITY: begin
        if (r_rx_cnt == BIT_LAST) begin
          w_rx_cnt_nxt     = '0;
          // Even parity: data plus parity bit must XOR to zero.
          w_rx_par_bad_nxt = r_rx_s2 ^ (^r_rx_shift);
          w_rx_state_nxt   = R_STOP;
        end
      end
`endif
      R_STOP: begin
        if (r_rx_stop_bad) begin
          // Framing error: hold off until the line returns to idle.
          if (r_rx_s2) begin
            w_rx_stop_bad_nxt = 1'b0;
            w_rx_state_nxt    = R_IDLE;
          end
        end else if (r_rx_cnt == BIT_LAST) begin
          if (r_rx_s2) begin
            w_rx_state_nxt = R_IDLE;
            if (w_rx_par_ok) begin
              // Data and count change on the same edge.
              w_rhr_data_nxt      = r_rx_shift;
              w_rx_data_ready_nxt = r_rx_data_ready + 8'd1;
            end else begin
              w_rx_error_nxt = 1'b1;
            end
          end else begin
            w_rx_error_nxt    = 1'b1;
            w_rx_stop_bad_nxt = 1'b1;
          end
        end
      end
      default: w_rx_state_nxt = R_IDLE;
    endcase
  end

  assign bus.rhr_data      = r_rhr_data;
  assign bus.rx_data_ready = r_rx_data_ready;
  assign bus.rx_error      = r_rx_error;

  // ---------------------------------------------------------------- TX
  logic        r_tx_load_d;
  tx_state_t   r_tx_state, w_tx_state_nxt;
  logic [15:0] r_tx_cnt, w_tx_cnt_nxt;
  logic [2:0]  r_tx_idx, w_tx_idx_nxt;
  logic [7:0]  r_tx_shift, w_tx_shift_nxt;
  logic        r_tx, w_tx_nxt;
  logic        r_tx_busy, w_tx_busy_nxt;
  logic [7:0]  r_tx_count, w_tx_count_nxt;
  logic        w_tx_load_rise;

`ifdef UART_LINK_PARITY_EN
  logic        r_tx_par, w_tx_par_nxt;
`endif

  assign w_tx_load_rise = bus.tx_load & ~r_tx_load_d;

  // TX state and datapath registers; tx itself is a flop so it never glitches.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // Delayed copy resets high so a tx_load held through reset is not an edge.
      r_tx_load_d <= 1'b1;
      r_tx_state  <= T_IDLE;
      r_tx_cnt    <= '0;
      r_tx_idx    <= '0;
      r_tx_shift  <= '0;
      r_tx        <= 1'b1;
      r_tx_busy   <= 1'b0;
      r_tx_count  <= '0;
`ifdef UART_LINK_PARITY_EN
      r_tx_par    <= 1'b0;
`endif
    end else begin
      r_tx_load_d <= bus.tx_load;
      r_tx_state  <= w_tx_state_nxt;
      r_tx_cnt    <= w_tx_cnt_nxt;
      r_tx_idx    <= w_tx_idx_nxt;
      r_tx_shift  <= w_tx_shift_nxt;
      r_tx        <= w_tx_nxt;
      r_tx_busy   <= w_tx_busy_nxt;
      r_tx_count  <= w_tx_count_nxt;
`ifdef UART_LINK_PARITY_EN
      r_tx_par    <= w_tx_par_nxt;
`endif
    end
  end

  // TX next-state: each bit is driven for exactly CLKS_PER_BIT cycles.
  always_comb begin
    w_tx_state_nxt = r_tx_state;
    w_tx_cnt_nxt   = r_tx_cnt + 16'd1;
    w_tx_idx_nxt   = r_tx_idx;
    w_tx_shift_nxt = r_tx_shift;
    w_tx_nxt       = r_tx;
    w_tx_busy_nxt  = r_tx_busy;
    w_tx_count_nxt = r_tx_count;
`ifdef UART_LINK_PARITY_EN
    w_tx_par_nxt   = r_tx_par;
`endif
    case (r_tx_state)
      T_IDLE: begin
        w_tx_cnt_nxt = '0;
        if (w_tx_load_rise) begin
          w_tx_busy_nxt  = 1'b1;
          w_tx_state_nxt = T_ARM;
        end
      end
      T_ARM: begin
        // Data is taken one cycle after the load edge.
        w_tx_shift_nxt = bus.tx_out_data;
`ifdef UART_LINK_PARITY_EN
        w_tx_par_nxt   = ^bus.tx_out_data;
`endif
        w_tx_cnt_nxt   = '0;
        w_tx_nxt       = 1'b0;
        w_tx_state_nxt = T_START;
      end
      T_START: begin
        if (r_tx_cnt == BIT_LAST) begin
          w_tx_cnt_nxt   = '0;
          w_tx_idx_nxt   = '0;
          w_tx_nxt       = r_tx_shift[0];
          w_tx_shift_nxt = {1'b0, r_tx_shift[7:1]};
          w_tx_state_nxt = T_DATA;
        end
      end
      T_DATA: begin
        if (r_tx_cnt == BIT_LAST) begin
          w_tx_cnt_nxt = '0;
          w_tx_idx_nxt = r_tx_idx + 3'd1;
          if (r_tx_idx == 3'd7) begin
`ifdef UART_LINK_PARITY_EN
            w_tx_nxt       = r_tx_par;
            w_tx_state_nxt = T_PARITY;
`else
            w_tx_nxt       = 1'b1;
            w_tx_state_nxt = T_STOP;
`endif
          end else begin
            w_tx_nxt       = r_tx_shift[0];
            w_tx_shift_nxt = {1'b0, r_tx_shift[7:1]};
          end
        end
      end
`ifdef UART_LINK_PARITY_EN
      T_PARITY: begin
        if (r_tx_cnt == BIT_LAST) begin
          w_tx_cnt_nxt   = '0;
          w_tx_nxt       = 1'b1;
          w_tx_state_nxt = T_STOP;
        end
      end
`endif
      T_STOP: begin
        if (r_tx_cnt == BIT_LAST) begin
          w_tx_cnt_nxt   = '0;
          w_tx_count_nxt = r_tx_count + 8'd1;
          w_tx_busy_nxt  = 1'b0;
          w_tx_state_nxt = T_IDLE;
        end
      end
      default: w_tx_state_nxt = T_IDLE;
    endcase
  end

  assign bus.tx       = r_tx;
  assign bus.tx_busy  = r_tx_busy;
  assign bus.tx_count = r_tx_count;

endmodule

// File: tb/tb_uart_link.sv
// tb_uart_link -- scoreboard bench for uart_link (8N1, CLKS_PER_BIT=16).
// Stimulus pushes expected RX bytes/counts and TX bytes into queues; two
// monitors pop and compare when the DUT bumps rx_data_ready or frames a byte
// on tx. Directed checks cover reset, timing, glitch, framing error, ignored
// loads, wrap-around and reset mid-frame.
module tb_uart_link;
  localparam int CPB = 16;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  uart_link_if u_if ();

  uart_link #(.CLKS_PER_BIT(CPB)) u_dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (u_if)
  );

  typedef struct {
    logic [7:0] data;
    logic [7:0] count;
  } rx_exp_t;

  rx_exp_t    rx_q[$];
  logic [7:0] tx_q[$];
  logic [7:0] exp_rx_cnt;
  logic [7:0] exp_tx_cnt;
  bit         reset_seen;
  int         n_pass  = 0;
  int         n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // ------------------------------------------------------------ monitors
  always @(negedge reset_n) reset_seen = 1'b1;

  // RX monitor: every change of rx_data_ready must match the next expectation.
  initial begin
    logic [7:0] prev;
    rx_exp_t    e;
    prev = 8'd0;
    forever begin
      @(negedge clk);
      if (!reset_n) prev = 8'd0;
      else if (u_if.rx_data_ready !== prev) begin
        if (rx_q.size() == 0) check("rx_queue_nonempty", 32'(rx_q.size()), 32'd1);
        else begin
          e = rx_q.pop_front();
          check("rx_data", 32'(u_if.rhr_data), 32'(e.data));
          check("rx_count", 32'(u_if.rx_data_ready), 32'(e.count));
        end
        prev = u_if.rx_data_ready;
      end
    end
  end

  // TX monitor: decode each frame at bit midpoints; frames cut by reset are dropped.
  initial begin
    logic       prev_tx;
    logic [7:0] b;
    logic       st, sp;
    prev_tx = 1'b1;
    forever begin
      @(negedge clk);
      if (reset_n && prev_tx === 1'b1 && u_if.tx === 1'b0) begin
        reset_seen = 1'b0;
        repeat (CPB / 2) @(negedge clk);
        st = u_if.tx;
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          b[i] = u_if.tx;
        end
        repeat (CPB) @(negedge clk);
        sp = u_if.tx;
        if (!reset_seen) begin
          check("tx_start_bit", 32'(st), 32'd0);
          check("tx_stop_bit", 32'(sp), 32'd1);
          if (tx_q.size() == 0) check("tx_queue_nonempty", 32'(tx_q.size()), 32'd1);
          else check("tx_byte", 32'(b), 32'(tx_q.pop_front()));
        end
      end
      prev_tx = u_if.tx;
    end
  end

  // ------------------------------------------------------------ stimulus
  task automatic drive_bit(input logic v);
    u_if.rx = v;
    repeat (CPB) @(negedge clk);
  endtask

  // Sends one frame on rx; a good stop bit queues the expected byte and count.
  task automatic send_rx(input logic [7:0] d, input logic stop_bit);
    if (stop_bit) begin
      exp_rx_cnt = exp_rx_cnt + 8'd1;
      rx_q.push_back('{d, exp_rx_cnt});
    end
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(stop_bit);
    if (!stop_bit) begin
      u_if.rx = 1'b1;
      repeat (40) @(negedge clk);
    end
  endtask

  // One-cycle tx_load pulse, data valid the following cycle; returns busy length.
  task automatic pulse_tx(input logic [7:0] d, input bit expect_sent, output int n);
    u_if.tx_load     = 1'b1;
    u_if.tx_out_data = ~d;
    @(negedge clk);
    u_if.tx_load     = 1'b0;
    u_if.tx_out_data = d;
    if (expect_sent) begin
      tx_q.push_back(d);
      exp_tx_cnt = exp_tx_cnt + 8'd1;
    end
    n = 0;
    while (u_if.tx_busy === 1'b1 && n < 400) begin
      n++;
      @(negedge clk);
      if (n == 1) u_if.tx_out_data = ~d;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
    $fatal(1);
  end

  initial begin
    int n;
    u_if.rx          = 1'b1;
    u_if.tx_load     = 1'b0;
    u_if.tx_out_data = 8'h00;
    exp_rx_cnt       = 8'd0;
    exp_tx_cnt       = 8'd0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_tx", 32'(u_if.tx), 32'd1);
    check("rst_rhr_data", 32'(u_if.rhr_data), 32'd0);
    check("rst_rx_data_ready", 32'(u_if.rx_data_ready), 32'd0);
    check("rst_rx_error", 32'(u_if.rx_error), 32'd0);
    check("rst_tx_count", 32'(u_if.tx_count), 32'd0);
    check("rst_tx_busy", 32'(u_if.tx_busy), 32'd0);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);

    // RX of 0xA5
    send_rx(8'hA5, 1'b1);
    check("rx_a5_data", 32'(u_if.rhr_data), 32'hA5);
    check("rx_a5_count", 32'(u_if.rx_data_ready), 32'd1);
    check("rx_a5_error", 32'(u_if.rx_error), 32'd0);
    repeat (10) @(negedge clk);

    // TX of 0x3C: busy for 161 cycles, one count
    pulse_tx(8'h3C, 1'b1, n);
    check("tx_3c_busy_cycles", 32'(n), 32'd161);
    check("tx_3c_count", 32'(u_if.tx_count), 32'(exp_tx_cnt));
    check("tx_3c_idle_line", 32'(u_if.tx), 32'd1);
    repeat (10) @(negedge clk);

    // Second load edge while busy is ignored
    fork
      pulse_tx(8'h81, 1'b1, n);
      begin
        repeat (50) @(negedge clk);
        u_if.tx_load     = 1'b1;
        u_if.tx_out_data = 8'hFF;
        @(negedge clk);
        u_if.tx_load     = 1'b0;
      end
    join
    check("tx_81_busy_cycles", 32'(n), 32'd161);
    repeat (40) @(negedge clk);
    check("tx_ignored_no_rearm", 32'(u_if.tx_busy), 32'd0);
    check("tx_ignored_count", 32'(u_if.tx_count), 32'(exp_tx_cnt));

    // 5-cycle glitch on rx: no byte, no error
    u_if.rx = 1'b0;
    repeat (5) @(negedge clk);
    u_if.rx = 1'b1;
    repeat (40) @(negedge clk);
    check("glitch_count", 32'(u_if.rx_data_ready), 32'(exp_rx_cnt));
    check("glitch_error", 32'(u_if.rx_error), 32'd0);

    // Stop bit 0: sticky error, no byte
    send_rx(8'h5A, 1'b0);
    check("badstop_error", 32'(u_if.rx_error), 32'd1);
    check("badstop_count", 32'(u_if.rx_data_ready), 32'(exp_rx_cnt));
    check("badstop_rhr_kept", 32'(u_if.rhr_data), 32'hA5);

    // Full duplex: RX 0x55 while TX 0xAA
    fork
      send_rx(8'h55, 1'b1);
      pulse_tx(8'hAA, 1'b1, n);
    join
    check("duplex_tx_busy_cycles", 32'(n), 32'd161);
    check("duplex_tx_count", 32'(u_if.tx_count), 32'(exp_tx_cnt));
    check("duplex_rx_count", 32'(u_if.rx_data_ready), 32'(exp_rx_cnt));
    check("duplex_rx_error_sticky", 32'(u_if.rx_error), 32'd1);
    repeat (20) @(negedge clk);

    // Reset mid-TX at bit 4 of 0xC3 (bit 4 is 0)
    u_if.tx_load = 1'b1;
    @(negedge clk);
    u_if.tx_load     = 1'b0;
    u_if.tx_out_data = 8'hC3;
    repeat (85) @(negedge clk);
    check("midtx_bit4_low", 32'(u_if.tx), 32'd0);
    reset_n = 1'b0;
    #1;
    check("midtx_reset_tx_high", 32'(u_if.tx), 32'd1);
    check("midtx_reset_tx_count", 32'(u_if.tx_count), 32'd0);
    check("midtx_reset_tx_busy", 32'(u_if.tx_busy), 32'd0);
    check("midtx_reset_rx_error", 32'(u_if.rx_error), 32'd0);
    check("midtx_reset_rx_count", 32'(u_if.rx_data_ready), 32'd0);
    exp_rx_cnt   = 8'd0;
    exp_tx_cnt   = 8'd0;
    u_if.tx_load = 1'b1;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (20) @(negedge clk);
    check("held_load_not_edge", 32'(u_if.tx_busy), 32'd0);
    u_if.tx_load = 1'b0;
    repeat (100) @(negedge clk);
    pulse_tx(8'h3C, 1'b1, n);
    check("post_reset_busy_cycles", 32'(n), 32'd161);
    check("post_reset_tx_count", 32'(u_if.tx_count), 32'd1);
    repeat (10) @(negedge clk);

    // 256 bytes: count wraps back to 0
    for (int i = 0; i < 256; i++) send_rx(8'(i) ^ 8'h3A, 1'b1);
    repeat (5) @(negedge clk);
    check("wrap_count", 32'(u_if.rx_data_ready), 32'd0);
    check("wrap_last_data", 32'(u_if.rhr_data), 32'hC5);
    check("wrap_error", 32'(u_if.rx_error), 32'd0);

    repeat (20) @(negedge clk);
    check("rx_q_drained", 32'(rx_q.size()), 32'd0);
    check("tx_q_drained", 32'(tx_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
